// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: grants one memory request at a time from NUM_CLIENTS
// requesters to the single-outstanding memory port. Arbitration is round-robin
// or fixed-priority. Completions are routed back to the owning client, and a
// watchdog aborts transactions that hang in BUSY.
module mem_req_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 512,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                buffer_addr_valid,
  input  logic [NUM_CLIENTS-1:0]              cl_req_valid,
  input  logic [NUM_CLIENTS-1:0]              cl_req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]       cl_req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0]       cl_req_wdata,
  output logic [NUM_CLIENTS-1:0]              cl_req_ready,
  output logic [NUM_CLIENTS-1:0]              cl_rd_valid,
  output logic [NUM_CLIENTS-1:0]              cl_wr_done,
  output logic [DATA_W-1:0]                   cl_rd_data,
  output logic                                mem_read_request_valid,
  output logic                                mem_write_request_valid,
  output logic [ADDR_W-1:0]                   mem_address,
  output logic [DATA_W-1:0]                   mem_data_d,
  input  logic                                mem_data_valid,
  input  logic                                mem_write_done,
  input  logic [DATA_W-1:0]                   mem_data_q,
  output logic                                busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]      owner,
  output logic                                timeout_err
);

  localparam int OWN_W     = $clog2(NUM_CLIENTS);
  localparam int WD_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int WD_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_LAST_I[WD_W-1:0];
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NUM_CLIENTS - 1);
  localparam logic [NUM_CLIENTS-1:0] ONE_N = NUM_CLIENTS'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NUM_CLIENTS-1:0]   req_ready_q, req_ready_d;
  logic [NUM_CLIENTS-1:0]   rd_valid_q, rd_valid_d;
  logic [NUM_CLIENTS-1:0]   wr_done_q, wr_done_d;
  logic [DATA_W-1:0]        rd_data_q, rd_data_d;
  logic                     rd_req_q, rd_req_d;
  logic                     wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     is_write_q, is_write_d;
  logic [OWN_W-1:0]         owner_q, owner_d;
  logic [OWN_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]          wdog_q, wdog_d;
  logic                     timeout_err_q, timeout_err_d;

  logic                     win_found;
  logic [OWN_W-1:0]         win_idx;
  logic [NUM_CLIENTS-1:0]   owner_oh;
  logic                     completion;

  // Pick the winning client: scan from rr_ptr with wrap-around in round-robin
  // mode, or from index 0 upward in fixed-priority mode.
  always_comb begin
    int idx_i;
    logic [OWN_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (ARB_MODE == 1) idx_i = k;
      else               idx_i = (int'(rr_ptr_q) + k) % NUM_CLIENTS;
      idx = OWN_W'(idx_i);
      if (!win_found && cl_req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign owner_oh   = ONE_N << owner_q;
  assign completion = is_write_q ? mem_write_done : mem_data_valid;

  // Next-state and next-output computation for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = '0;
    rd_valid_d    = '0;
    wr_done_d     = '0;
    rd_data_d     = rd_data_q;
    rd_req_d      = rd_req_q;
    wr_req_d      = wr_req_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    is_write_d    = is_write_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (buffer_addr_valid && win_found) begin
          req_ready_d = ONE_N << win_idx;
          addr_d      = cl_req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d     = cl_req_wdata[int'(win_idx)*DATA_W +: DATA_W];
          is_write_d  = cl_req_write[win_idx];
          rd_req_d    = ~cl_req_write[win_idx];
          wr_req_d    = cl_req_write[win_idx];
          owner_d     = win_idx;
          rr_ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          wdog_d      = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (completion) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          if (!is_write_q) rd_data_d = mem_data_q;
          state_d  = DONE;
        end else if (TIMEOUT_CYC != 0 && wdog_q == WD_LAST) begin
          rd_req_d      = 1'b0;
          wr_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      DONE: begin
        if (is_write_q) wr_done_d  = owner_oh;
        else            rd_valid_d = owner_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= '0;
      rd_valid_q    <= '0;
      wr_done_q     <= '0;
      rd_data_q     <= '0;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      is_write_q    <= 1'b0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rd_valid_q    <= rd_valid_d;
      wr_done_q     <= wr_done_d;
      rd_data_q     <= rd_data_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      is_write_q    <= is_write_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cl_req_ready            = req_ready_q;
  assign cl_rd_valid             = rd_valid_q;
  assign cl_wr_done              = wr_done_q;
  assign cl_rd_data              = rd_data_q;
  assign mem_read_request_valid  = rd_req_q;
  assign mem_write_request_valid = wr_req_q;
  assign mem_address             = addr_q;
  assign mem_data_d              = wdata_q;
  assign busy                    = (state_q != IDLE);
  assign owner                   = owner_q;
  assign timeout_err             = timeout_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed, self-checking bench for mem_req_arbiter.
// A round-robin instance covers the main flows and the watchdog; a
// fixed-priority instance covers priority ordering.
module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            bav;
  logic [N-1:0]    valid, write, fp_valid;
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] wdata_bus;
  logic            mdv, mwd;
  logic [DW-1:0]   mdq;

  logic [N-1:0]  ready, rdv, wrd;
  logic [DW-1:0] rdata, mdata_d;
  logic          rreq, wreq, busy, terr;
  logic [AW-1:0] maddr;
  logic [1:0]    owner;

  logic [N-1:0]  fp_ready, fp_rdv, fp_wrd;
  logic [DW-1:0] fp_rdata, fp_mdata_d;
  logic          fp_rreq, fp_wreq, fp_busy, fp_terr;
  logic [AW-1:0] fp_maddr;
  logic [1:0]    fp_owner;

  mem_req_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYC(16)) dut_rr (
    .clk(clk), .rst_n(rst_n), .buffer_addr_valid(bav),
    .cl_req_valid(valid), .cl_req_write(write), .cl_req_addr(addr_bus), .cl_req_wdata(wdata_bus),
    .cl_req_ready(ready), .cl_rd_valid(rdv), .cl_wr_done(wrd), .cl_rd_data(rdata),
    .mem_read_request_valid(rreq), .mem_write_request_valid(wreq),
    .mem_address(maddr), .mem_data_d(mdata_d),
    .mem_data_valid(mdv), .mem_write_done(mwd), .mem_data_q(mdq),
    .busy(busy), .owner(owner), .timeout_err(terr)
  );

  mem_req_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYC(16)) dut_fp (
    .clk(clk), .rst_n(rst_n), .buffer_addr_valid(bav),
    .cl_req_valid(fp_valid), .cl_req_write(write), .cl_req_addr(addr_bus), .cl_req_wdata(wdata_bus),
    .cl_req_ready(fp_ready), .cl_rd_valid(fp_rdv), .cl_wr_done(fp_wrd), .cl_rd_data(fp_rdata),
    .mem_read_request_valid(fp_rreq), .mem_write_request_valid(fp_wreq),
    .mem_address(fp_maddr), .mem_data_d(fp_mdata_d),
    .mem_data_valid(mdv), .mem_write_done(mwd), .mem_data_q(mdq),
    .busy(fp_busy), .owner(fp_owner), .timeout_err(fp_terr)
  );

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] write;
    int           lat;
    int           exp_owner;
  } vec_t;

  vec_t vecs [8];
  int checks   = 0;
  int failures = 0;

  // One comparison: count it, and report a FAIL line on mismatch.
  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  function automatic logic [AW-1:0] caddr(input int i);
    return addr_bus[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] cwdata(input int i);
    return wdata_bus[i*DW +: DW];
  endfunction

  // Drive one table entry as a single transaction and check grant and response.
  task automatic apply_stimulus(input int e);
    int wt;
    logic w;
    logic [DW-1:0] exp_data;
    valid = vecs[e].valid;
    write = vecs[e].write;
    wt = 0;
    step();
    while (ready == '0 && wt < 10) begin
      step();
      wt++;
    end
    w = vecs[e].write[vecs[e].exp_owner];
    check_output($sformatf("vec%0d ready", e), DW'(ready), DW'(onehot(vecs[e].exp_owner)));
    check_output($sformatf("vec%0d owner", e), DW'(owner), DW'(vecs[e].exp_owner));
    check_output($sformatf("vec%0d addr", e), DW'(maddr), DW'(caddr(vecs[e].exp_owner)));
    check_output($sformatf("vec%0d rd_req", e), DW'(rreq), DW'(!w));
    check_output($sformatf("vec%0d wr_req", e), DW'(wreq), DW'(w));
    if (w) check_output($sformatf("vec%0d wdata", e), mdata_d, cwdata(vecs[e].exp_owner));
    valid = '0;
    repeat (vecs[e].lat) step();
    exp_data = {16{32'hC0DE0000 + 32'(e)}};
    if (w) mwd = 1'b1;
    else begin
      mdv = 1'b1;
      mdq = exp_data;
    end
    step();
    mwd = 1'b0;
    mdv = 1'b0;
    check_output($sformatf("vec%0d req dropped", e), DW'(rreq | wreq), DW'(0));
    step();
    check_output($sformatf("vec%0d rd_valid", e), DW'(rdv), DW'(w ? 4'b0000 : onehot(vecs[e].exp_owner)));
    check_output($sformatf("vec%0d wr_done", e), DW'(wrd), DW'(w ? onehot(vecs[e].exp_owner) : 4'b0000));
    if (!w) check_output($sformatf("vec%0d rd_data", e), rdata, exp_data);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int hi, cnt, g, last, fp_pulses;
    logic seen;

    rst_n    = 1'b0;
    bav      = 1'b0;
    valid    = '0;
    write    = '0;
    fp_valid = '0;
    mdv      = 1'b0;
    mwd      = 1'b0;
    mdq      = '0;
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AW +: AW]  = 32'h1000 + 32'(i * 64);
      wdata_bus[i*DW +: DW] = {16{32'hD0 + 32'(i)}};
    end
    addr_bus[2*AW +: AW] = 32'h40;

    vecs[0] = '{4'b1111, 4'b0000, 0, 3};
    vecs[1] = '{4'b0110, 4'b0010, 2, 1};
    vecs[2] = '{4'b0011, 4'b0000, 1, 0};
    vecs[3] = '{4'b1001, 4'b1000, 3, 3};
    vecs[4] = '{4'b1000, 4'b0000, 0, 3};
    vecs[5] = '{4'b0001, 4'b0000, 1, 0};
    vecs[6] = '{4'b0101, 4'b0100, 4, 2};
    vecs[7] = '{4'b0011, 4'b0000, 2, 0};

    // Reset values
    repeat (3) step();
    check_output("reset ready", DW'(ready), DW'(0));
    check_output("reset req", DW'({rreq, wreq}), DW'(0));
    check_output("reset busy", DW'(busy), DW'(0));
    check_output("reset owner", DW'(owner), DW'(0));
    check_output("reset terr", DW'(terr), DW'(0));
    check_output("reset rdata", rdata, '0);
    check_output("reset addr", DW'(maddr), DW'(0));
    rst_n = 1'b1;
    bav   = 1'b1;
    step();

    // Single read by client 2, memory answers in the sixth request cycle
    valid = 4'b0100;
    write = '0;
    step();
    check_output("single ready", DW'(ready), DW'(4'b0100));
    check_output("single rd_req", DW'(rreq), DW'(1));
    check_output("single addr", DW'(maddr), DW'(32'h40));
    check_output("single owner", DW'(owner), DW'(2));
    valid = '0;
    hi = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) check_output("single ready pulse width", DW'(ready), DW'(0));
      if (rreq) hi++;
    end
    mdv = 1'b1;
    mdq = {64{8'hA5}};
    step();
    mdv = 1'b0;
    check_output("single rd_req dropped", DW'(rreq), DW'(0));
    check_output("single rd_req cycles", DW'(hi), DW'(6));
    step();
    check_output("single rd_valid", DW'(rdv), DW'(4'b0100));
    check_output("single rd_data", rdata, {64{8'hA5}});
    step();
    check_output("single rd_valid pulse width", DW'(rdv), DW'(0));

    // Table-driven transactions
    for (int e = 0; e < 8; e++) apply_stimulus(e);

    // Round-robin fairness: all clients request continuously, latency 1
    valid = 4'b1111;
    write = '0;
    g = 0;
    last = 0;
    for (int cyc = 0; cyc < 80 && g < 8; cyc++) begin
      step();
      if (ready != '0) begin
        check_output($sformatf("rr grant %0d", g), DW'(ready), DW'(onehot((1 + g) % 4)));
        if (g > 0) check_output($sformatf("rr spacing %0d", g), DW'(cyc - last), DW'(4));
        last = cyc;
        g++;
        mdv = 1'b0;
        if (g == 8) valid = '0;
      end else begin
        mdv = rreq;
      end
    end
    check_output("rr grant count", DW'(g), DW'(8));
    for (int k = 0; k < 6; k++) begin
      step();
      mdv = rreq;
    end
    mdv = 1'b0;
    step();

    // Address-valid gate, then a write that ignores read strobes
    bav   = 1'b0;
    valid = 4'b0010;
    write = 4'b0010;
    cnt = 0;
    repeat (20) begin
      step();
      if (ready != '0) cnt++;
    end
    check_output("gate no grant", DW'(cnt), DW'(0));
    check_output("gate not busy", DW'(busy), DW'(0));
    bav = 1'b1;
    step();
    check_output("gate grant", DW'(ready), DW'(4'b0010));
    check_output("gate wr_req", DW'({rreq, wreq}), DW'(2'b01));
    valid = '0;
    bav   = 1'b0;
    mdv   = 1'b1;
    step();
    step();
    check_output("write ignores rd strobe", DW'({wreq, busy}), DW'(2'b11));
    mdv = 1'b0;
    mwd = 1'b1;
    step();
    mwd = 1'b0;
    check_output("write dropped", DW'(wreq), DW'(0));
    step();
    check_output("write done pulse", DW'(wrd), DW'(4'b0010));
    check_output("write no rd_valid", DW'(rdv), DW'(0));
    bav   = 1'b1;
    write = '0;
    step();

    // Watchdog: client 3 wins and memory stays silent; client 0 is pending
    valid = 4'b1001;
    step();
    check_output("wdog grant", DW'(ready), DW'(4'b1000));
    valid = 4'b0001;
    hi = 1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rdv != '0) seen = 1'b1;
      if (!rreq) break;
      hi++;
    end
    check_output("wdog busy cycles", DW'(hi), DW'(16));
    check_output("wdog terr set", DW'(terr), DW'(1));
    check_output("wdog no response", DW'(seen), DW'(0));
    check_output("wdog idle", DW'(busy), DW'(0));
    step();
    check_output("wdog next grant", DW'(ready), DW'(4'b0001));
    valid = '0;
    mdv   = 1'b1;
    mdq   = {16{32'h5EED0000}};
    step();
    mdv = 1'b0;
    step();
    check_output("wdog next rd_valid", DW'(rdv), DW'(4'b0001));
    check_output("wdog terr sticky", DW'(terr), DW'(1));
    step();

    // Fixed priority: clients 0 and 3 both request, latency 1
    fp_valid  = 4'b1001;
    g         = 0;
    fp_pulses = 0;
    for (int cyc = 0; cyc < 80 && g < 5; cyc++) begin
      step();
      if (fp_rdv != '0) fp_pulses++;
      if (fp_ready != '0) begin
        check_output($sformatf("fp grant %0d", g), DW'(fp_ready), DW'(g < 4 ? 4'b0001 : 4'b1000));
        g++;
        mdv = 1'b0;
        if (g == 4) fp_valid = 4'b1000;
        if (g == 5) fp_valid = '0;
      end else begin
        mdv = fp_rreq;
      end
    end
    check_output("fp grant count", DW'(g), DW'(5));
    for (int k = 0; k < 6; k++) begin
      step();
      if (fp_rdv != '0) fp_pulses++;
      mdv = fp_rreq;
    end
    mdv = 1'b0;
    check_output("fp rd_valid pulses", DW'(fp_pulses), DW'(5));
    check_output("fp final owner", DW'(fp_owner), DW'(3));
    check_output("fp final addr", DW'(fp_maddr), DW'(caddr(3)));
    check_output("fp latched wdata", fp_mdata_d, cwdata(3));
    check_output("fp rd_data", fp_rdata, {16{32'h5EED0000}});
    check_output("fp idle flags", DW'({fp_busy, fp_rreq, fp_wreq, fp_terr, fp_wrd}), DW'(0));
    step();

    // Reset during BUSY clears everything at once and resets rr_ptr
    valid = 4'b0100;
    step();
    check_output("rst pre grant", DW'(ready), DW'(4'b0100));
    valid = '0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst async req", DW'({rreq, wreq}), DW'(0));
    check_output("rst async busy", DW'(busy), DW'(0));
    check_output("rst async terr", DW'(terr), DW'(0));
    check_output("rst async rdata", rdata, '0);
    check_output("rst async addr", DW'(maddr), DW'(0));
    check_output("rst async owner", DW'(owner), DW'(0));
    step();
    step();
    rst_n = 1'b1;
    valid = 4'b1001;
    step();
    check_output("rst first grant", DW'(ready), DW'(4'b0001));
    valid = '0;
    mdv   = 1'b1;
    step();
    mdv = 1'b0;
    step();
    check_output("rst first rd_valid", DW'(rdv), DW'(4'b0001));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised memory-port arbiter that sits between the AFU pipeline clients and the single-outstanding CCI-P `memory` block. It replaces the hard-wired request muxing in `control_wrapper`. It accepts read/write requests from NUM_CLIENTS requesters (IPGU pixel fetch, RDN weights, DNN weights, DNN result writeback, …) and grants one at a time, round-robin or fixed-priority. It routes the completion back to the owning client and flags hung transactions with a watchdog.

## Interface
- NUM_CLIENTS, 4: number of requesters, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 512: cache-line data width.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, client 0 highest.
- TIMEOUT_CYC, 1024: max cycles in BUSY before abort; 0 disables the watchdog.

- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- buffer_addr_valid  in  1  memory base address known; no grant while low.
- cl_req_valid  in  NUM_CLIENTS  per-client request; held until the matching cl_req_ready.
- cl_req_write  in  NUM_CLIENTS  1 = write, 0 = read.
- cl_req_addr  in  NUM_CLIENTS*ADDR_W  client i at [i*ADDR_W +: ADDR_W].
- cl_req_wdata  in  NUM_CLIENTS*DATA_W  client i at [i*DATA_W +: DATA_W].
- cl_req_ready  out  NUM_CLIENTS  one-hot 1-cycle accept pulse.
- cl_rd_valid  out  NUM_CLIENTS  one-hot 1-cycle read-data pulse.
- cl_wr_done  out  NUM_CLIENTS  one-hot 1-cycle write-complete pulse.
- cl_rd_data  out  DATA_W  shared read data, valid with cl_rd_valid.
- mem_read_request_valid  out  1  level, held until completion.
- mem_write_request_valid  out  1  level, held until completion.
- mem_address  out  ADDR_W  latched address.
- mem_data_d  out  DATA_W  latched write data.
- mem_data_valid  in  1  read completion strobe.
- mem_write_done  in  1  write completion strobe.
- mem_data_q  in  DATA_W  read data, valid with mem_data_valid.
- busy  out  1  high in BUSY and DONE.
- owner  out  $clog2(NUM_CLIENTS)  index of the current/last granted client.
- timeout_err  out  1  sticky; set on watchdog abort.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If buffer_addr_valid and any cl_req_valid: choose winner w, latch addr/wdata/write of w, owner<=w, pulse cl_req_ready[w], go BUSY.
  - Otherwise stay in IDLE.
- **Arbitration**
  - ARB_MODE 0: search starts at rr_ptr, wrapping N-1 -> 0. After a grant to w, rr_ptr <= (w+1) mod N. rr_ptr resets to 0.
  - ARB_MODE 1: lowest asserted index wins; rr_ptr is unused.
- **BUSY**
  - Assert mem_read_request_valid or mem_write_request_valid (per the latched type). mem_address and mem_data_d are stable throughout.
  - Completion is mem_data_valid for a read, mem_write_done for a write. The strobe of the other type is ignored.
  - On completion: drop the request, register mem_data_q into cl_rd_data (reads only), go DONE.
  - The watchdog counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYC: drop the request, set timeout_err, go IDLE with no response pulse.
- **DONE**
  - Pulse cl_rd_valid[owner] or cl_wr_done[owner] for one cycle, then go IDLE.
- Completion strobes in IDLE or DONE are ignored.
- buffer_addr_valid falling during BUSY does not abort the transaction.
- A client that drops cl_req_valid after its grant has no effect; its request was already latched.
- timeout_err is cleared only by rst_n.

## Timing
- Reset: state IDLE; all outputs 0; cl_rd_data 0; rr_ptr 0; watchdog 0.
- Request first seen in IDLE at cycle t:
  - cl_req_ready at t+1 (registered).
  - mem request valid high from t+1.
- Completion strobe at cycle c: mem request low at c+1; response pulse and cl_rd_data valid at c+2.
- Earliest next grant is at c+3.
- Minimum transaction period: 3 cycles plus memory latency.
- Reset asserted mid-BUSY: outputs clear asynchronously. No response is issued and the in-flight request is lost.

## Test plan
- **Single read:** client 2 reads addr 0x40 and memory returns 0xA5 (replicated) after 5 cycles. Expect:
  - cl_req_ready = 4'b0100 one cycle after request.
  - mem_read_request_valid high for 6 cycles, mem_address = 0x40.
  - cl_rd_valid = 4'b0100 with cl_rd_data = 0xA5…
- **Round-robin fairness:** all 4 clients hold valid, memory answers in 1 cycle. Grant order 0,1,2,3,0,… Each grant is 4 cycles apart, and no client is granted twice before the others.
- **Fixed priority:** ARB_MODE=1, clients 0 and 3 both request continuously. Only client 0 is granted; client 3 is granted only after client 0 drops valid.
- **Gate and type filtering:**
  - With buffer_addr_valid=0 and requests pending for 20 cycles: no cl_req_ready pulses. Raising it produces a grant one cycle later.
  - During a write, a mem_data_valid strobe is ignored; the write completes only on mem_write_done.
- **Watchdog:** TIMEOUT_CYC=16 and memory never responds. Expect:
  - Request dropped after 16 BUSY cycles.
  - timeout_err=1 and stays 1.
  - No cl_rd_valid pulse.
  - The next pending client is granted normally.
- **Reset mid-transaction:** rst_n low during BUSY. All outputs are 0 immediately and timeout_err is cleared. After release, the first grant goes to client 0 (rr_ptr reset).
